multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mips_ctrl_pkg.sv | 58 +++++
 rtl/mc_wait_timer.sv | 36 +++
 rtl/multicycle_control.sv | 176 +++++++++++++++++
 tb/tb_multicycle_control.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, FSM states,
// datapath select codes and the packed control word.
package mips_ctrl_pkg;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [3:0] StFetch   = 4'd0;
    localparam logic [3:0] StDecode  = 4'd1;
    localparam logic [3:0] StMemAdr  = 4'd2;
    localparam logic [3:0] StMemRd   = 4'd3;
    localparam logic [3:0] StMemWb   = 4'd4;
    localparam logic [3:0] StMemWr   = 4'd5;
    localparam logic [3:0] StRtypeEx = 4'd6;
    localparam logic [3:0] StAluWb   = 4'd7;
    localparam logic [3:0] StBeqEx   = 4'd8;
    localparam logic [3:0] StAddiEx  = 4'd9;
    localparam logic [3:0] StAddiWb  = 4'd10;
    localparam logic [3:0] StJEx     = 4'd11;
    localparam logic [3:0] StHalt    = 4'd12;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;

    localparam logic [1:0] SrcBRegB  = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] PcAlu    = 2'b00;
    localparam logic [1:0] PcAluOut = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;

    typedef struct packed {
        logic       pcWrite;
        logic       branch;
        logic       iOrD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memToReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSrc;
        logic       instrDone;
        logic       illegalOp;
        logic       error;
    } ctrlT;

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts consecutive not-ready cycles of one access and
// flags the cycle in which the TIMEOUT-th wait would be reached.
module mc_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic memReady,
    output logic timeout
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CntW-1:0] countQ, countD;

    // Leaving a wait state (or completing the access) clears the count, so every
    // FETCH/MEMRD/MEMWR entry starts from zero.
    always_comb begin
        countD = countQ + 1'b1;
        if (!waiting || memReady) begin
            countD = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            countQ <= '0;
        end else begin
            countQ <= countD;
        end
    end

    assign timeout = waiting && !memReady && (countQ == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute states and
// decodes the datapath control word, halting on a memory handshake timeout.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       branch,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       error
);

    logic [3:0] stateQ, stateD;
    logic       waiting, timeout;
    ctrlT       ctrl;

    assign waiting = (stateQ == StFetch) || (stateQ == StMemRd) || (stateQ == StMemWr);

    mc_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .waiting  (waiting),
        .memReady (mem_ready),
        .timeout  (timeout)
    );

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            StFetch: begin
                if (mem_ready)    stateD = StDecode;
                else if (timeout) stateD = StHalt;
            end
            StDecode: begin
                case (opcode)
                    OpRtype:    stateD = StRtypeEx;
                    OpLw, OpSw: stateD = StMemAdr;
                    OpBeq:      stateD = StBeqEx;
                    OpAddi:     stateD = StAddiEx;
                    OpJ:        stateD = StJEx;
                    default:    stateD = StFetch;
                endcase
            end
            StMemAdr:  stateD = (opcode == OpLw) ? StMemRd : StMemWr;
            StMemRd: begin
                if (mem_ready)    stateD = StMemWb;
                else if (timeout) stateD = StHalt;
            end
            StMemWr: begin
                if (mem_ready)    stateD = StFetch;
                else if (timeout) stateD = StHalt;
            end
            StRtypeEx: stateD = StAluWb;
            StAddiEx:  stateD = StAddiWb;
            StMemWb, StAluWb, StBeqEx, StAddiWb, StJEx: stateD = StFetch;
            StHalt:    stateD = StHalt;
            default:   stateD = StHalt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= StFetch;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        ctrl = '0;
        case (stateQ)
            StFetch: begin
                ctrl.memRead = 1'b1;
                ctrl.aluSrcB = SrcBFour;
                ctrl.aluOp   = AluAdd;
                ctrl.pcSrc   = PcAlu;
                ctrl.irWrite = mem_ready;
                ctrl.pcWrite = mem_ready;
            end
            StDecode: begin
                ctrl.aluSrcB   = SrcBImmSh;
                ctrl.aluOp     = AluAdd;
                ctrl.illegalOp = !(opcode inside {OpRtype, OpLw, OpSw, OpBeq, OpAddi, OpJ});
            end
            StMemAdr, StAddiEx: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SrcBImm;
                ctrl.aluOp   = AluAdd;
            end
            StMemRd: begin
                ctrl.memRead = 1'b1;
                ctrl.iOrD    = 1'b1;
            end
            StMemWb: begin
                ctrl.regWrite  = 1'b1;
                ctrl.memToReg  = 1'b1;
                ctrl.instrDone = 1'b1;
            end
            StMemWr: begin
                ctrl.memWrite  = 1'b1;
                ctrl.iOrD      = 1'b1;
                ctrl.instrDone = mem_ready;
            end
            StRtypeEx: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SrcBRegB;
                ctrl.aluOp   = AluFunct;
            end
            StAluWb: begin
                ctrl.regWrite  = 1'b1;
                ctrl.regDst    = 1'b1;
                ctrl.instrDone = 1'b1;
            end
            StBeqEx: begin
                ctrl.aluSrcA   = 1'b1;
                ctrl.aluSrcB   = SrcBRegB;
                ctrl.aluOp     = AluSub;
                ctrl.branch    = 1'b1;
                ctrl.pcSrc     = PcAluOut;
                ctrl.instrDone = 1'b1;
            end
            StAddiWb: begin
                ctrl.regWrite  = 1'b1;
                ctrl.instrDone = 1'b1;
            end
            StJEx: begin
                ctrl.pcWrite   = 1'b1;
                ctrl.pcSrc     = PcJump;
                ctrl.instrDone = 1'b1;
            end
            StHalt:  ctrl.error = 1'b1;
            default: ctrl = '0;
        endcase
        // Outputs are forced low combinationally so reset silences an access at once.
        if (reset) begin
            ctrl = '0;
        end
    end

    assign pc_write   = ctrl.pcWrite;
    assign branch     = ctrl.branch;
    assign i_or_d     = ctrl.iOrD;
    assign mem_read   = ctrl.memRead;
    assign mem_write  = ctrl.memWrite;
    assign ir_write   = ctrl.irWrite;
    assign mem_to_reg = ctrl.memToReg;
    assign reg_dst    = ctrl.regDst;
    assign reg_write  = ctrl.regWrite;
    assign alu_src_a  = ctrl.aluSrcA;
    assign alu_src_b  = ctrl.aluSrcB;
    assign alu_op     = ctrl.aluOp;
    assign pc_src     = ctrl.pcSrc;
    assign instr_done = ctrl.instrDone;
    assign illegal_op = ctrl.illegalOp;
    assign error      = ctrl.error;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class, stalls,
// the ready-wins timeout boundary, reset mid-access and HALT.
module tb_multicycle_control;

    logic       clk, reset, mem_ready;
    logic [5:0] opcode;
    logic       pc_write, branch, i_or_d, mem_read, mem_write, ir_write, mem_to_reg;
    logic       reg_dst, reg_write, alu_src_a, instr_done, illegal_op, error;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [18:0] obs;

    int passed = 0;
    int total  = 0;

    multicycle_control #(
        .TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .branch     (branch),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .mem_to_reg (mem_to_reg),
        .reg_dst    (reg_dst),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .error      (error)
    );

    assign obs = {pc_write, branch, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
                  reg_write, alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal_op, error};

    // Field order: pw br iod mr mw irw m2r rd rw asa | asb | aop | psrc | done ill err
    localparam logic [18:0] eZero      = {10'b0000000000, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [18:0] eFetchWait = {10'b0001000000, 2'b01, 2'b00, 2'b00, 3'b000};
    localparam logic [18:0] eFetchGo   = {10'b1001010000, 2'b01, 2'b00, 2'b00, 3'b000};
    localparam logic [18:0] eDecode    = {10'b0000000000, 2'b11, 2'b00, 2'b00, 3'b000};
    localparam logic [18:0] eDecodeIll = {10'b0000000000, 2'b11, 2'b00, 2'b00, 3'b010};
    localparam logic [18:0] eMemAdr    = {10'b0000000001, 2'b10, 2'b00, 2'b00, 3'b000};
    localparam logic [18:0] eMemRd     = {10'b0011000000, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [18:0] eMemWb     = {10'b0000001010, 2'b00, 2'b00, 2'b00, 3'b100};
    localparam logic [18:0] eMemWrWait = {10'b0010100000, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [18:0] eMemWrGo   = {10'b0010100000, 2'b00, 2'b00, 2'b00, 3'b100};
    localparam logic [18:0] eRtype     = {10'b0000000001, 2'b00, 2'b10, 2'b00, 3'b000};
    localparam logic [18:0] eAluWb     = {10'b0000000110, 2'b00, 2'b00, 2'b00, 3'b100};
    localparam logic [18:0] eBeq       = {10'b0100000001, 2'b00, 2'b01, 2'b01, 3'b100};
    localparam logic [18:0] eAddiEx    = {10'b0000000001, 2'b10, 2'b00, 2'b00, 3'b000};
    localparam logic [18:0] eAddiWb    = {10'b0000000010, 2'b00, 2'b00, 2'b00, 3'b100};
    localparam logic [18:0] eJ         = {10'b1000000000, 2'b00, 2'b00, 2'b10, 3'b100};
    localparam logic [18:0] eHalt      = {10'b0000000000, 2'b00, 2'b00, 2'b00, 3'b001};

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time budget");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [18:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %b required %b", tag, obs, expv);
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance.
    task automatic cyc(input logic [5:0] op, input logic rdy, input logic [18:0] expv,
                       input string tag);
        opcode    = op;
        mem_ready = rdy;
        #1;
        chk(tag, expv);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; opcode = R; mem_ready = 1'b1;
        @(posedge clk); #1;
        cyc(R, 1'b1, eZero, "reset_outputs");
        reset = 1'b0;

        cyc(R, 1'b1, eFetchGo, "r_fetch");
        cyc(R, 1'b1, eDecode,  "r_decode");
        cyc(R, 1'b1, eRtype,   "r_ex");
        cyc(R, 1'b1, eAluWb,   "r_wb");

        cyc(LW, 1'b1, eFetchGo, "lw_fetch");
        cyc(LW, 1'b1, eDecode,  "lw_decode");
        cyc(LW, 1'b1, eMemAdr,  "lw_adr");
        cyc(LW, 1'b1, eMemRd,   "lw_rd");
        cyc(LW, 1'b1, eMemWb,   "lw_wb");

        cyc(SW, 1'b1, eFetchGo, "sw_fetch");
        cyc(SW, 1'b1, eDecode,  "sw_decode");
        cyc(SW, 1'b1, eMemAdr,  "sw_adr");
        cyc(SW, 1'b1, eMemWrGo, "sw_wr");

        cyc(BEQ, 1'b1, eFetchGo, "beq_fetch");
        cyc(BEQ, 1'b0, eDecode,  "beq_decode_ready_ignored");
        cyc(BEQ, 1'b1, eBeq,     "beq_ex");

        cyc(J, 1'b1, eFetchGo, "j_fetch");
        cyc(J, 1'b1, eDecode,  "j_decode");
        cyc(J, 1'b1, eJ,       "j_ex");

        cyc(ADDI, 1'b1, eFetchGo, "addi_fetch");
        cyc(ADDI, 1'b1, eDecode,  "addi_decode");
        cyc(ADDI, 1'b1, eAddiEx,  "addi_ex");
        cyc(ADDI, 1'b1, eAddiWb,  "addi_wb");

        cyc(BAD, 1'b1, eFetchGo,   "bad_fetch");
        cyc(BAD, 1'b1, eDecodeIll, "bad_decode");
        cyc(BAD, 1'b0, eFetchWait, "bad_back_fetch");

        cyc(LW, 1'b1, eFetchGo, "lws_fetch");
        cyc(LW, 1'b1, eDecode,  "lws_decode");
        cyc(LW, 1'b1, eMemAdr,  "lws_adr");
        for (int i = 0; i < 3; i++) cyc(LW, 1'b0, eMemRd, "lws_rd_wait");
        cyc(LW, 1'b1, eMemRd,   "lws_rd_go");
        cyc(LW, 1'b1, eMemWb,   "lws_wb");

        // Ready arriving in the 16th wait cycle still completes the fetch.
        for (int i = 0; i < 15; i++) cyc(J, 1'b0, eFetchWait, "edge_fetch_wait");
        cyc(J, 1'b1, eFetchGo, "edge_ready_wins");
        cyc(J, 1'b1, eDecode,  "edge_decode");
        cyc(J, 1'b1, eJ,       "edge_j");

        cyc(SW, 1'b1, eFetchGo,   "rsw_fetch");
        cyc(SW, 1'b1, eDecode,    "rsw_decode");
        cyc(SW, 1'b1, eMemAdr,    "rsw_adr");
        cyc(SW, 1'b0, eMemWrWait, "rsw_wr_wait");
        reset = 1'b1;
        cyc(SW, 1'b1, eZero, "rsw_reset_drop");
        reset = 1'b0;
        cyc(SW, 1'b0, eFetchWait, "rsw_fetch_after");

        // Previous cycle was wait #1; fifteen more reach the timeout.
        for (int i = 0; i < 15; i++) cyc(R, 1'b0, eFetchWait, "to_fetch_wait");
        cyc(R, 1'b1, eHalt, "to_halt");
        cyc(R, 1'b0, eHalt, "to_halt_hold");
        cyc(R, 1'b1, eHalt, "to_halt_hold2");
        reset = 1'b1;
        cyc(R, 1'b1, eZero, "halt_reset");
        reset = 1'b0;
        cyc(R, 1'b1, eFetchGo, "halt_exit_fetch");
        cyc(R, 1'b1, eDecode,  "halt_exit_decode");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
